// File: rtl/fpdp_multiply.sv
// rtl/fpdp_multiply.sv - binary64 multiplier, 53-cycle shift-add mantissa loop, tagged request/done
// Optional FPDP_MUL_ROUND_EN: round-to-nearest-even; otherwise truncate toward zero.
module fpdp_multiply (
  input  logic        clk,
  input  logic        rset,
  input  logic [63:0] fpdp_multiplier,
  input  logic [63:0] fpdp_multiplicand,
  input  logic [3:0]  ready,
  output logic [63:0] fpdp_product,
  output logic [3:0]  done
);

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]         tag;
  logic               sign;
  logic signed [12:0] exp_r;
  logic [105:0]       ma_sh;
  logic [52:0]        mb_sh;
  logic [105:0]       acc;
  logic [5:0]         cnt;
  logic               special;
  logic [63:0]        special_val;

  // Operand classification, only meaningful while capturing in IDLE
  logic [10:0] ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_in;
  logic        cap_special;
  logic [63:0] cap_special_val;

  always_comb begin
    ea     = fpdp_multiplier[62:52];
    eb     = fpdp_multiplicand[62:52];
    s_in   = fpdp_multiplier[63] ^ fpdp_multiplicand[63];
    a_nan  = (ea == 11'h7FF) && (fpdp_multiplier[51:0] != 52'd0);
    b_nan  = (eb == 11'h7FF) && (fpdp_multiplicand[51:0] != 52'd0);
    a_inf  = (ea == 11'h7FF) && (fpdp_multiplier[51:0] == 52'd0);
    b_inf  = (eb == 11'h7FF) && (fpdp_multiplicand[51:0] == 52'd0);
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    cap_special     = 1'b1;
    cap_special_val = 64'h7FF8000000000000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      cap_special_val = 64'h7FF8000000000000;
    end else if (a_inf || b_inf) begin
      cap_special_val = {s_in, 11'h7FF, 52'd0};
    end else if (a_zero || b_zero) begin
      cap_special_val = {s_in, 63'd0};
    end else begin
      cap_special = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rset) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready != 4'd0) state_nxt = MUL;
      MUL:     if (cnt == 6'd52) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Normalized product has its leading 1 at bit 104; fraction is [103:52]
  logic [53:0]        mant_rnd;
  logic               carry;
  logic signed [12:0] exp_fin;
  logic [51:0]        frac_fin;
  logic [63:0]        result;

`ifdef FPDP_MUL_ROUND_EN
  logic guard, sticky, round_up;
  always_comb begin
    guard    = acc[51];
    sticky   = |acc[50:0];
    round_up = guard & (sticky | acc[52]);
    mant_rnd = {2'b01, acc[103:52]} + {53'd0, round_up};
  end
`else
  assign mant_rnd = {2'b01, acc[103:52]};
`endif

  always_comb begin
    carry    = mant_rnd[53];
    exp_fin  = exp_r + $signed({12'd0, carry});
    frac_fin = carry ? mant_rnd[52:1] : mant_rnd[51:0];
    if (special)                    result = special_val;
    else if (exp_fin >= 13'sd2047)  result = {sign, 11'h7FF, 52'd0};
    else if (exp_fin <= 13'sd0)     result = {sign, 63'd0};
    else                            result = {sign, exp_fin[10:0], frac_fin};
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      tag          <= 4'd0;
      sign         <= 1'b0;
      exp_r        <= 13'sd0;
      ma_sh        <= 106'd0;
      mb_sh        <= 53'd0;
      acc          <= 106'd0;
      cnt          <= 6'd0;
      special      <= 1'b0;
      special_val  <= 64'd0;
      fpdp_product <= 64'd0;
      done         <= 4'd0;
    end else begin
      done <= 4'd0;
      case (state)
        IDLE: if (ready != 4'd0) begin
          tag         <= ready;
          sign        <= s_in;
          exp_r       <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
          ma_sh       <= {53'd0, 1'b1, fpdp_multiplier[51:0]};
          mb_sh       <= {1'b1, fpdp_multiplicand[51:0]};
          acc         <= 106'd0;
          cnt         <= 6'd0;
          special     <= cap_special;
          special_val <= cap_special_val;
        end
        MUL: begin
          if (mb_sh[0]) acc <= acc + ma_sh;
          ma_sh <= ma_sh << 1;
          mb_sh <= mb_sh >> 1;
          cnt   <= cnt + 6'd1;
        end
        NORM: if (acc[105]) begin
          // Fold the shifted-out bit into the sticky region
          acc   <= {1'b0, acc[105:1]} | {105'd0, acc[0]};
          exp_r <= exp_r + 13'sd1;
        end
        ROUND: begin
          fpdp_product <= result;
          done         <= tag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdp_multiply.sv
// tb/tb_fpdp_multiply.sv - self-checking bench for fpdp_multiply with arithmetic reference model
module tb_fpdp_multiply;

  logic        clk = 1'b0;
  logic        rset;
  logic [63:0] fpdp_multiplier;
  logic [63:0] fpdp_multiplicand;
  logic [3:0]  ready;
  logic [63:0] fpdp_product;
  logic [3:0]  done;

  int errors = 0;
  int checks = 0;

  fpdp_multiply dut (
    .clk(clk), .rset(rset),
    .fpdp_multiplier(fpdp_multiplier), .fpdp_multiplicand(fpdp_multiplicand),
    .ready(ready), .fpdp_product(fpdp_product), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic s;
    int ea, eb, e;
    logic [51:0] fa, fb;
    logic [105:0] ma, mb, m;
    logic [53:0] q, rem, half;
    s  = a[63] ^ b[63];
    ea = int'(a[62:52]); eb = int'(b[62:52]);
    fa = a[51:0];        fb = b[51:0];
    if ((ea == 2047 && fa != 0) || (eb == 2047 && fb != 0) ||
        (ea == 2047 && eb == 0) || (eb == 2047 && ea == 0))
      return 64'h7FF8000000000000;
    if (ea == 2047 || eb == 2047) return {s, 11'h7FF, 52'd0};
    if (ea == 0 || eb == 0) return {s, 63'd0};
    ma = {53'd0, 1'b1, fa};
    mb = {53'd0, 1'b1, fb};
    m  = ma * mb;
    e  = ea + eb - 1023;
    if (m >= (106'd1 << 105)) begin
      e++;
      q    = {1'b0, m[105:53]};
      rem  = {1'b0, m[52:0]};
      half = 54'd1 << 52;
    end else begin
      q    = {1'b0, m[104:52]};
      rem  = {2'b00, m[51:0]};
      half = 54'd1 << 51;
    end
`ifdef FPDP_MUL_ROUND_EN
    if (rem > half || (rem == half && q[0])) q = q + 54'd1;
    if (q == (54'd1 << 53)) begin
      q = q >> 1;
      e++;
    end
`else
    if (rem > half) q = q; // truncation keeps q unchanged
`endif
    if (e >= 2047) return {s, 11'h7FF, 52'd0};
    if (e <= 0) return {s, 63'd0};
    return {s, e[10:0], q[51:0]};
  endfunction

  // Issue one request from IDLE, check latency, result, tag and pulse width
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t,
                       input logic [63:0] exp, input string nm);
    int lat;
    fpdp_multiplier = a;
    fpdp_multiplicand = b;
    ready = t;
    @(posedge clk); #1;
    ready = 4'd0;
    lat = 0;
    while (done == 4'd0 && lat < 70) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd55);
    chk({nm, "_tag"}, {60'd0, done}, {60'd0, t});
    chk({nm, "_product"}, fpdp_product, exp);
    @(posedge clk); #1;
    chk({nm, "_done_clear"}, {60'd0, done}, 64'd0);
  endtask

  function automatic logic [63:0] rand_norm();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[62:52] = 11'($urandom_range(900, 1150));
    return r;
  endfunction

  initial begin
    logic [63:0] a, b;
    logic [3:0]  t;
    int lat;
    int seen;

    rset = 1'b1;
    ready = 4'd0;
    fpdp_multiplier = 64'd0;
    fpdp_multiplicand = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", fpdp_product, 64'd0);
    chk("reset_done", {60'd0, done}, 64'd0);
    rset = 1'b0;
    @(posedge clk); #1;

    // Held ready: first pulse 55 edges after capture, then every 57 cycles
    fpdp_multiplier = 64'h3FEE000000000000;
    fpdp_multiplicand = 64'h3FEA000000000000;
    ready = 4'd1;
    lat = 0;
    while (done == 4'd0 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_first_latency", 64'(lat), 64'd56);
    chk("held_first_done", {60'd0, done}, 64'd1);
    chk("held_first_product", fpdp_product, 64'h3FE8600000000000);
    @(posedge clk); #1;
    chk("held_pulse_width", {60'd0, done}, 64'd0);
    lat = 1;
    while (done == 4'd0 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    ready = 4'd0;
    chk("held_period", 64'(lat), 64'd57);
    chk("held_second_product", fpdp_product, 64'h3FE8600000000000);
    @(posedge clk); #1;

    do_op(64'h4000000000000000, 64'h4008000000000000, 4'hA, 64'h4018000000000000, "two_x_three");
    do_op(64'hBFF8000000000000, 64'h4000000000000000, 4'h3, 64'hC008000000000000, "neg");
    do_op(64'h7FF0000000000000, 64'h0000000000000000, 4'h5, 64'h7FF8000000000000, "inf_x_zero");
    do_op(64'h7FE0000000000000, 64'h4000000000000000, 4'h7, 64'h7FF0000000000000, "overflow");
    do_op(64'h0000000000000001, 64'h4000000000000000, 4'h9, 64'h0000000000000000, "denormal");
`ifdef FPDP_MUL_ROUND_EN
    do_op(64'h3FF0000000000001, 64'h3FF8000000000000, 4'hF, 64'h3FF8000000000002, "tie_round");
`else
    do_op(64'h3FF0000000000001, 64'h3FF8000000000000, 4'hF, 64'h3FF8000000000001, "tie_round");
`endif

    // Reset 20 cycles into an operation, with ready asserted on the reset edge
    fpdp_multiplier = 64'h4000000000000000;
    fpdp_multiplicand = 64'h4008000000000000;
    ready = 4'h2;
    @(posedge clk); #1;
    ready = 4'd0;
    repeat (19) @(posedge clk);
    #1;
    rset = 1'b1;
    ready = 4'h5;
    @(posedge clk); #1;
    rset = 1'b0;
    ready = 4'd0;
    chk("midop_reset_product", fpdp_product, 64'd0);
    chk("midop_reset_done", {60'd0, done}, 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done != 4'd0) seen = 1;
    end
    chk("midop_no_done", 64'(seen), 64'd0);
    do_op(64'h3FEE000000000000, 64'h3FEA000000000000, 4'h6, 64'h3FE8600000000000, "after_reset");

    for (int i = 0; i < 16; i++) begin
      a = rand_norm();
      b = rand_norm();
      t = 4'($urandom_range(1, 15));
      do_op(a, b, t, ref_mul(a, b), "rand_norm");
    end
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      t = 4'($urandom_range(1, 15));
      do_op(a, b, t, ref_mul(a, b), "rand_full");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
